// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between instruction fetch (I)
// and the load-store queue (D); holds the winning request until the memory responds.
module mem_port_arbiter #(
  parameter int unsigned width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,

  input  logic                 i_mem_read,
  input  logic [width-1:0]     i_mem_address,
  output logic                 i_mem_resp,
  output logic [width-1:0]     i_mem_rdata,

  input  logic                 d_mem_read,
  input  logic                 d_mem_write,
  input  logic [width/8-1:0]   d_mem_byte_enable,
  input  logic [width-1:0]     d_mem_address,
  input  logic [width-1:0]     d_mem_wdata,
  output logic                 d_mem_resp,
  output logic [width-1:0]     d_mem_rdata,

  output logic                 mem_read,
  output logic                 mem_write,
  output logic [width/8-1:0]   mem_byte_enable,
  output logic [width-1:0]     mem_address,
  output logic [width-1:0]     mem_wdata,
  input  logic                 mem_resp,
  input  logic [width-1:0]     mem_rdata
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  localparam logic GrantI = 1'b0;
  localparam logic GrantD = 1'b1;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 i_drop_q, i_drop_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [width/8-1:0]   be_q, be_d;
  logic [width-1:0]     addr_q, addr_d;
  logic [width-1:0]     wdata_q, wdata_d;

  logic i_req, d_req;

  assign i_req = i_mem_read & ~flush;
  assign d_req = d_mem_read | d_mem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
      i_drop_q     <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      i_drop_q     <= i_drop_d;
      read_q       <= read_d;
      write_q      <= write_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    i_drop_d     = i_drop_q;
    read_d       = read_q;
    write_d      = write_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      StIdle: begin
        i_drop_d = 1'b0;
        // On a tie the side that did not win last time goes first.
        if (d_req && (!i_req || (last_grant_q == GrantI))) begin
          state_d      = StServeD;
          last_grant_d = GrantD;
          write_d      = d_mem_write;
          read_d       = ~d_mem_write;
          be_d         = d_mem_byte_enable;
          addr_d       = d_mem_address;
          wdata_d      = d_mem_wdata;
        end else if (i_req) begin
          state_d      = StServeI;
          last_grant_d = GrantI;
          read_d       = 1'b1;
          write_d      = 1'b0;
          be_d         = '1;
          addr_d       = i_mem_address;
          wdata_d      = '0;
        end
      end
      StServeI, StServeD: begin
        if (state_q == StServeI && flush) begin
          i_drop_d = 1'b1;
        end
        // Memory transactions are never aborted; only completion releases the port.
        if (mem_resp) begin
          state_d  = StIdle;
          i_drop_d = 1'b0;
          read_d   = 1'b0;
          write_d  = 1'b0;
          be_d     = '0;
          wdata_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign i_mem_resp      = mem_resp & (state_q == StServeI) & ~flush & ~i_drop_q;
  assign d_mem_resp      = mem_resp & (state_q == StServeD);
  assign i_mem_rdata     = mem_rdata;
  assign d_mem_rdata     = mem_rdata;

  assign mem_read        = read_q;
  assign mem_write       = write_q;
  assign mem_byte_enable = be_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;

endmodule
